// File: rtl/mpt_walk_stage.sv
// MPT walker stage: multi-level table walk through a single-outstanding read port,
// emitting {leaf mpte, transaction} or the transaction flagged with an access error.
module mpt_walk_stage #(
  parameter int PIPELINE_SLAVE_DATA_WIDTH  = 32,
  parameter int PIPELINE_MASTER_DATA_WIDTH = PIPELINE_SLAVE_DATA_WIDTH + 64,
  parameter int IDX_W                      = 9,
  parameter int PAGE_SHIFT                 = 12,
  parameter int ADDR_W                     = 56,
  parameter int PPN_W                      = 12
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  stage_slave_valid,
  output logic                                  stage_slave_ready,
  input  logic [PIPELINE_SLAVE_DATA_WIDTH-1:0]  stage_slave_data,
  output logic                                  stage_master_valid,
  input  logic                                  stage_master_ready,
  output logic [PIPELINE_MASTER_DATA_WIDTH-1:0] stage_master_data,
  input  logic                                  stage_ctrl_valid,
  input  logic [0:0]                            stage_ctrl_data,
  output logic                                  stage_status_valid,
  output logic [0:0]                            stage_status_data,
  output logic                                  mem_req_valid_o,
  input  logic                                  mem_req_ready_i,
  output logic [ADDR_W-1:0]                     mem_req_addr_o,
  input  logic                                  mem_rsp_valid_i,
  input  logic [63:0]                           mem_rsp_data_i,
  input  logic                                  mem_rsp_error_i
);

  // Transaction layout, LSB first: valid, walking, access_error, mmpt.MODE[3:0], mmpt.PPN, spa.
  localparam int SW        = PIPELINE_SLAVE_DATA_WIDTH;
  localparam int VALID_B   = 0;
  localparam int WALK_B    = 1;
  localparam int AE_B      = 2;
  localparam int MODE_LSB  = 3;
  localparam int PPN_LSB   = 7;
  localparam int SPA_LSB   = PPN_LSB + PPN_W;
  localparam int SPA_W     = SW - SPA_LSB;

  localparam logic       MPT_WALKING_SKIP = 1'b1;
  localparam logic [0:0] FLUSH_CMD        = 1'b1;
  localparam logic [0:0] FLUSH_DONE       = 1'b1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_OUT   = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [SW-1:0]     txn_q, txn_d;
  logic [63:0]       mpte_q, mpte_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [2:0]        level_q, level_d;
  logic              ready_q, ready_d;
  logic              status_q, status_d;

  logic                     flush;
  logic [SPA_W+IDX_W-1:0]   spa_ext, spa_sh;
  logic [IDX_W-1:0]         idx;
  logic [ADDR_W-1:0]        req_addr;
  logic [ADDR_W-1:0]        entry_base;
  logic [ADDR_W-1:0]        root_base;
  logic [3:0]               in_mode;
  logic [2:0]               in_level;
  logic                     in_mode_ok;
  logic                     in_skip;

  assign flush = stage_ctrl_valid && (stage_ctrl_data == FLUSH_CMD);

  // Index bits above the stored spa field read as zero.
  always_comb begin
    spa_ext  = {{IDX_W{1'b0}}, txn_q[SPA_LSB +: SPA_W]};
    spa_sh   = spa_ext >> (PAGE_SHIFT + IDX_W * 32'(level_q));
    idx      = spa_sh[IDX_W-1:0];
    req_addr = base_q + ADDR_W'({idx, 3'b000});
  end

  assign entry_base = ADDR_W'({mem_rsp_data_i[53:10], {PAGE_SHIFT{1'b0}}});
  assign root_base  = ADDR_W'({stage_slave_data[PPN_LSB +: PPN_W], {PAGE_SHIFT{1'b0}}});
  assign in_mode    = stage_slave_data[MODE_LSB +: 4];
  assign in_skip    = !stage_slave_data[VALID_B] ||
                      (stage_slave_data[WALK_B] == MPT_WALKING_SKIP) ||
                      stage_slave_data[AE_B];

  // Modes without a defined walk depth are flagged as access errors.
  always_comb begin
    in_level   = 3'd0;
    in_mode_ok = 1'b1;
    case (in_mode)
      4'd1:    in_level = 3'd1;
      4'd2:    in_level = 3'd2;
      4'd3:    in_level = 3'd3;
      4'd4:    in_level = 3'd4;
      default: in_mode_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    txn_d    = txn_q;
    mpte_d   = mpte_q;
    base_d   = base_q;
    level_d  = level_q;
    status_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (flush) begin
          status_d = 1'b1;
        end else if (stage_slave_valid && ready_q) begin
          txn_d  = stage_slave_data;
          mpte_d = '0;
          if (in_skip) begin
            state_d = S_OUT;
          end else if (!in_mode_ok) begin
            txn_d[AE_B] = 1'b1;
            state_d     = S_OUT;
          end else begin
            level_d = in_level;
            base_d  = root_base;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (flush) begin
          state_d  = S_IDLE;
          status_d = 1'b1;
        end else if (mem_req_ready_i) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (flush) begin
          state_d = S_DRAIN;
        end else if (mem_rsp_valid_i) begin
          if (mem_rsp_error_i || !mem_rsp_data_i[0]) begin
            txn_d[AE_B] = 1'b1;
            mpte_d      = mem_rsp_data_i;
            state_d     = S_OUT;
          end else if (mem_rsp_data_i[1]) begin
            mpte_d  = mem_rsp_data_i;
            state_d = S_OUT;
          end else if (level_q != 3'd0) begin
            base_d  = entry_base;
            level_d = level_q - 3'd1;
            state_d = S_REQ;
          end else begin
            txn_d[AE_B] = 1'b1;
            state_d     = S_OUT;
          end
        end
      end
      S_OUT: begin
        if (flush) begin
          state_d  = S_IDLE;
          status_d = 1'b1;
        end else if (stage_master_ready) begin
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (mem_rsp_valid_i) begin
          state_d  = S_IDLE;
          status_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      txn_q    <= '0;
      mpte_q   <= '0;
      base_q   <= '0;
      level_q  <= '0;
      ready_q  <= 1'b0;
      status_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      txn_q    <= txn_d;
      mpte_q   <= mpte_d;
      base_q   <= base_d;
      level_q  <= level_d;
      ready_q  <= ready_d;
      status_q <= status_d;
    end
  end

  assign stage_slave_ready  = ready_q;
  assign stage_master_valid = (state_q == S_OUT);
  assign stage_master_data  = {mpte_q, txn_q};
  assign mem_req_valid_o    = (state_q == S_REQ);
  assign mem_req_addr_o     = (state_q == S_REQ) ? req_addr : '0;
  assign stage_status_valid = status_q;
  assign stage_status_data  = status_q ? FLUSH_DONE : '0;

endmodule

// File: tb/tb_mpt_walk_stage.sv
// Randomized and directed bench for mpt_walk_stage against a behavioural walk model.
module tb_mpt_walk_stage;
  localparam int SW = 96;
  localparam int MW = SW + 64;
  localparam int PPN_W = 44;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stage_slave_valid = 1'b0;
  logic stage_slave_ready;
  logic [SW-1:0] stage_slave_data = '0;
  logic stage_master_valid;
  logic stage_master_ready = 1'b0;
  logic [MW-1:0] stage_master_data;
  logic stage_ctrl_valid = 1'b0;
  logic [0:0] stage_ctrl_data = '0;
  logic stage_status_valid;
  logic [0:0] stage_status_data;
  logic mem_req_valid_o;
  logic mem_req_ready_i = 1'b0;
  logic [55:0] mem_req_addr_o;
  logic mem_rsp_valid_i = 1'b0;
  logic [63:0] mem_rsp_data_i = '0;
  logic mem_rsp_error_i = 1'b0;

  mpt_walk_stage #(
    .PIPELINE_SLAVE_DATA_WIDTH(SW),
    .PIPELINE_MASTER_DATA_WIDTH(MW),
    .IDX_W(9),
    .PAGE_SHIFT(12),
    .ADDR_W(56),
    .PPN_W(PPN_W)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .stage_slave_valid(stage_slave_valid), .stage_slave_ready(stage_slave_ready),
    .stage_slave_data(stage_slave_data),
    .stage_master_valid(stage_master_valid), .stage_master_ready(stage_master_ready),
    .stage_master_data(stage_master_data),
    .stage_ctrl_valid(stage_ctrl_valid), .stage_ctrl_data(stage_ctrl_data),
    .stage_status_valid(stage_status_valid), .stage_status_data(stage_status_data),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_req_addr_o(mem_req_addr_o),
    .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_data_i(mem_rsp_data_i),
    .mem_rsp_error_i(mem_rsp_error_i)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  logic [63:0] mem [logic [55:0]];
  bit          err_en = 0;
  logic [55:0] err_addr = '0;
  logic [55:0] exp_addrs[$];
  logic [55:0] got_addrs[$];
  logic [MW-1:0] got_data;
  int          got_lat;

  task automatic chk(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [SW-1:0] mk(bit v, bit skip, bit ae, logic [3:0] mode,
                                       logic [43:0] ppn, logic [44:0] spa);
    return {spa, ppn, mode, ae, skip, v};
  endfunction

  function automatic logic [63:0] mem_rd(logic [55:0] a);
    return mem.exists(a) ? mem[a] : 64'h0;
  endfunction

  // Reference walk: levels from mode, index arithmetic on spa, entry decoding by V/L bits.
  function automatic logic [MW-1:0] ref_walk(input logic [SW-1:0] t);
    longint unsigned spa, ppn, base, addr, idx;
    logic [63:0] e, mpte;
    logic [SW-1:0] o;
    int lvl;
    bit ae;
    o = t; ae = 0; mpte = 0;
    spa = 64'(t[95:51]);
    ppn = 64'(t[50:7]);
    exp_addrs.delete();
    if (t[0] && !t[1] && !t[2]) begin
      lvl = (t[6:3] >= 4'd1 && t[6:3] <= 4'd4) ? int'(t[6:3]) : -1;
      if (lvl < 0) ae = 1;
      else begin
        base = ppn * 4096;
        for (int l = lvl; l >= 0; l--) begin
          idx  = (spa >> (12 + 9 * l)) % 512;
          addr = (base + idx * 8) % (64'd1 << 56);
          exp_addrs.push_back(56'(addr));
          e = mem_rd(56'(addr));
          if ((err_en && 56'(addr) == err_addr) || !e[0]) begin ae = 1; mpte = e; break; end
          if (e[1]) begin mpte = e; break; end
          if (l == 0) begin ae = 1; break; end
          base = ((e >> 10) % (64'd1 << 44)) * 4096;
        end
      end
    end
    o[2] = o[2] | ae;
    return {mpte, o};
  endfunction

  task automatic run_txn(input logic [SW-1:0] t, input int rstall, input int ostall, input string tag);
    logic [MW-1:0] exp;
    logic [55:0] cur;
    int cyc, sl, ol, guard;
    bit ok, done, rsp_pend, req_seen, addr_ok;
    exp = ref_walk(t);
    got_addrs.delete();
    guard = 0;
    while (stage_slave_ready !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
    stage_slave_valid = 1; stage_slave_data = t;
    @(negedge clk);
    stage_slave_valid = 0; stage_slave_data = '0;
    cyc = 1; got_lat = -1; ok = 1; done = 0; rsp_pend = 0; req_seen = 0;
    sl = rstall; ol = ostall; cur = '0; got_data = '0;
    while (!done && cyc < 300) begin
      mem_rsp_valid_i = 0; mem_rsp_error_i = 0; mem_rsp_data_i = '0;
      if (rsp_pend) begin
        mem_rsp_valid_i = 1;
        mem_rsp_data_i  = mem_rd(cur);
        mem_rsp_error_i = err_en && (cur == err_addr);
        rsp_pend = 0;
        if (mem_req_valid_o !== 1'b0) ok = 0;
      end
      if (mem_req_valid_o === 1'b1) begin
        if (!req_seen) begin got_addrs.push_back(mem_req_addr_o); cur = mem_req_addr_o; req_seen = 1; end
        else if (mem_req_addr_o !== cur) ok = 0;
        if (sl > 0) begin mem_req_ready_i = 0; sl--; end
        else begin mem_req_ready_i = 1; rsp_pend = 1; req_seen = 0; sl = rstall; end
      end else mem_req_ready_i = 0;
      if (stage_slave_ready !== 1'b0) ok = 0;
      if (stage_master_valid === 1'b1) begin
        if (got_lat < 0) begin got_lat = cyc; got_data = stage_master_data; end
        else if (stage_master_data !== got_data) ok = 0;
        if (ol > 0) begin stage_master_ready = 0; ol--; end
        else begin stage_master_ready = 1; done = 1; end
      end else stage_master_ready = 0;
      @(negedge clk);
      cyc++;
    end
    mem_req_ready_i = 0; stage_master_ready = 0;
    mem_rsp_valid_i = 0; mem_rsp_error_i = 0; mem_rsp_data_i = '0;
    if (stage_slave_ready !== 1'b1 || stage_master_valid !== 1'b0) ok = 0;
    addr_ok = (got_addrs.size() == exp_addrs.size());
    if (addr_ok) foreach (got_addrs[i]) if (got_addrs[i] !== exp_addrs[i]) addr_ok = 0;
    chk({tag, "_done"}, MW'(done), MW'(1));
    chk({tag, "_data"}, got_data, exp);
    chk({tag, "_addrs"}, MW'(addr_ok), MW'(1));
    chk({tag, "_lat"}, MW'(got_lat), MW'(1 + (2 + rstall) * exp_addrs.size()));
    chk({tag, "_stable"}, MW'(ok), MW'(1));
  endtask

  logic [SW-1:0] t43;
  logic [SW-1:0] tr;
  bit fok;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_slave_ready", MW'(stage_slave_ready), MW'(0));
    chk("rst_master_valid", MW'(stage_master_valid), MW'(0));
    chk("rst_req_valid", MW'(mem_req_valid_o), MW'(0));
    chk("rst_status_valid", MW'(stage_status_valid), MW'(0));
    chk("rst_master_data", stage_master_data, MW'(0));
    rst = 0;
    @(negedge clk);
    chk("post_rst_ready", MW'(stage_slave_ready), MW'(1));

    // Skip pass-through
    mem.delete(); err_en = 0;
    tr = mk(1, 1, 0, 4'd2, 44'h100, 45'h1234);
    run_txn(tr, 0, 0, "skip");
    chk("skip_exact", got_data, {64'h0, tr});
    chk("skip_nreq", MW'(got_addrs.size()), MW'(0));

    // SMMPT43 three-level walk
    t43 = mk(1, 0, 0, 4'd2, 44'h100, 45'h1_40C0_7000);
    mem.delete();
    mem[56'h100028] = (64'h200 << 10) | 64'h1;
    mem[56'h200030] = (64'h300 << 10) | 64'h1;
    mem[56'h300038] = 64'h0000_0000_0010_0403;
    run_txn(t43, 0, 0, "walk43");
    chk("walk43_exact", got_data, {64'h0000_0000_0010_0403, t43});
    chk("walk43_lat7", MW'(got_lat), MW'(7));
    chk("walk43_a0", MW'(got_addrs.size() > 0 ? got_addrs[0] : 56'h0), MW'(56'h100028));
    chk("walk43_a2", MW'(got_addrs.size() > 2 ? got_addrs[2] : 56'h0), MW'(56'h300038));

    // Backpressure on both sides
    run_txn(t43, 3, 4, "bp");

    // Invalid level-2 entry
    mem.delete();
    run_txn(t43, 0, 0, "inval");
    chk("inval_exact", got_data, {64'h0, t43 | SW'(4)});
    chk("inval_nreq", MW'(got_addrs.size()), MW'(1));

    // Non-leaf at level 0
    mem[56'h100028] = (64'h200 << 10) | 64'h1;
    mem[56'h200030] = (64'h300 << 10) | 64'h1;
    mem[56'h300038] = (64'h400 << 10) | 64'h1;
    run_txn(t43, 0, 0, "nonleaf0");
    chk("nonleaf0_ae", MW'(got_data[2]), MW'(1));

    // Bus error on level-2 read
    mem[56'h100028] = 64'hABCD_0001;
    err_en = 1; err_addr = 56'h100028;
    run_txn(t43, 0, 0, "buserr");
    chk("buserr_exact", got_data, {64'hABCD_0001, t43 | SW'(4)});
    err_en = 0;

    // Flush while waiting for a response
    mem.delete();
    mem[56'h100028] = 64'h0000_0000_0010_0403;
    fok = 1;
    stage_slave_valid = 1; stage_slave_data = t43;
    @(negedge clk); stage_slave_valid = 0;
    mem_req_ready_i = 1;
    @(negedge clk); mem_req_ready_i = 0;
    stage_ctrl_valid = 1; stage_ctrl_data = 1'b1;
    @(negedge clk); stage_ctrl_valid = 0;
    if (stage_status_valid !== 1'b0 || mem_req_valid_o !== 1'b0 || stage_master_valid !== 1'b0) fok = 0;
    @(negedge clk);
    if (stage_status_valid !== 1'b0 || stage_master_valid !== 1'b0) fok = 0;
    mem_rsp_valid_i = 1; mem_rsp_data_i = 64'h0000_0000_0010_0403;
    @(negedge clk); mem_rsp_valid_i = 0; mem_rsp_data_i = '0;
    chk("fwait_status", MW'({stage_status_valid, stage_status_data}), MW'(2'b11));
    chk("fwait_ready", MW'(stage_slave_ready), MW'(1));
    if (stage_master_valid !== 1'b0) fok = 0;
    @(negedge clk);
    if (stage_status_valid !== 1'b0 || stage_master_valid !== 1'b0) fok = 0;
    chk("fwait_quiet", MW'(fok), MW'(1));
    run_txn(t43, 0, 0, "after_flush");

    // Flush in REQ with an unaccepted request
    stage_slave_valid = 1; stage_slave_data = t43;
    @(negedge clk); stage_slave_valid = 0;
    chk("freq_reqv", MW'(mem_req_valid_o), MW'(1));
    stage_ctrl_valid = 1;
    @(negedge clk); stage_ctrl_valid = 0;
    chk("freq_drop", MW'({mem_req_valid_o, stage_status_valid, stage_slave_ready}), MW'(3'b011));

    // Flush in IDLE while a transaction is offered
    stage_slave_valid = 1; stage_slave_data = t43; stage_ctrl_valid = 1;
    @(negedge clk); stage_slave_valid = 0; stage_ctrl_valid = 0;
    chk("fidle_noacc", MW'({mem_req_valid_o, stage_master_valid, stage_status_valid, stage_slave_ready}),
        MW'(4'b0011));
    @(negedge clk);

    // Randomized transactions
    for (int n = 0; n < 30; n++) begin
      logic [3:0] mode;
      logic [43:0] ppn;
      logic [44:0] spa;
      longint unsigned base, addr, idx;
      logic [63:0] e;
      int r;
      mem.delete(); err_en = 0;
      mode = ($urandom_range(0, 9) == 0) ? 4'(($urandom_range(0, 1) == 0) ? 0 : 7) : 4'($urandom_range(2, 4));
      ppn  = {12'($urandom), $urandom};
      spa  = {13'($urandom), $urandom};
      tr = mk($urandom_range(0, 9) != 0, $urandom_range(0, 6) == 0, $urandom_range(0, 9) == 0, mode, ppn, spa);
      if (mode >= 2 && mode <= 4) begin
        base = longint'(ppn) * 4096;
        for (int l = int'(mode); l >= 0; l--) begin
          idx  = (longint'(spa) >> (12 + 9 * l)) % 512;
          addr = (base + idx * 8) % (64'd1 << 56);
          r = $urandom_range(0, 9);
          e = {$urandom, $urandom};
          if (r == 0) e[0] = 0;
          else if (r == 1) begin err_en = 1; err_addr = 56'(addr); end
          else if (r <= 3) e[1:0] = 2'b11;
          else e[1:0] = 2'b01;
          if (!mem.exists(56'(addr))) mem[56'(addr)] = e;
          if (r <= 3) break;
          base = ((mem[56'(addr)] >> 10) % (64'd1 << 44)) * 4096;
        end
      end
      run_txn(tr, $urandom_range(0, 2), $urandom_range(0, 2), $sformatf("rnd%0d", n));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "bench timeout");
  end
endmodule

// File: doc/mpt_walk_stage.md
Name: mpt_walk_stage

Overview:
- Stage directly downstream of the fetch stage in the MPT walker pipeline.
- Consumes format-checked walk transactions and performs the multi-level MPT table walk through a single-outstanding memory read port.
- Emits the transaction with the leaf MPT entry appended, or with an access error, to the next (permission-check) stage.
- Carries one transaction at a time and honours pipeline flush.

Parameters:
- PIPELINE_SLAVE_DATA_WIDTH, 32, width of the incoming packed mptw_transaction_t.
- PIPELINE_MASTER_DATA_WIDTH, PIPELINE_SLAVE_DATA_WIDTH+64, width of the output {mpte[63:0], transaction}.
- IDX_W, 9, table index bits consumed per level.
- PAGE_SHIFT, 12, byte shift applied to a PPN to form a table base address.
- ADDR_W, 56, physical address width of memory requests.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- stage_slave_valid  in  1  upstream transaction valid.
- stage_slave_ready  out  1  block can accept a transaction.
- stage_slave_data  in  PIPELINE_SLAVE_DATA_WIDTH  mptw_transaction_t; fields used: valid, walking, mmpt.MODE, mmpt.PPN, spa, access_error.
- stage_master_valid  out  1  output transaction valid.
- stage_master_ready  in  1  downstream can accept.
- stage_master_data  out  PIPELINE_MASTER_DATA_WIDTH  {mpte, transaction}.
- stage_ctrl_valid  in  1  control command valid.
- stage_ctrl_data  in  $bits(mptw_flush_ctrl_e)  flush command.
- stage_status_valid  out  1  status valid.
- stage_status_data  out  $bits(mptw_flush_status_e)  flush done status.
- mem_req_valid_o  out  1  table read request.
- mem_req_ready_i  in  1  memory accepts the request.
- mem_req_addr_o  out  ADDR_W  8-byte-aligned entry address.
- mem_rsp_valid_i  in  1  read response valid; response is always accepted.
- mem_rsp_data_i  in  64  MPT entry.
- mem_rsp_error_i  in  1  bus error on the read.

Behaviour:
- Reset values: all valid outputs 0, stage_slave_ready 0, data outputs 0, FSM in IDLE.
- States: IDLE, REQ, WAIT, OUT, DRAIN.
- IDLE: stage_slave_ready=1. On valid&&ready, latch the transaction.
  - If data.valid==0, walking==MPT_WALKING_SKIP, or access_error!=0: set mpte=0 and go to OUT with no memory access.
  - Otherwise: level = 2 for SMMPT43, 3 for SMMPT52, 4 for SMMPT64; base = mmpt.PPN<<PAGE_SHIFT; go to REQ.
- REQ: mem_req_valid_o=1; addr = base + (spa[PAGE_SHIFT+IDX_W*level +: IDX_W] << 3). Address is truncated to ADDR_W. Request is held stable until mem_req_ready_i, then go to WAIT.
- WAIT: act on mem_rsp_valid_i.
  - mem_rsp_error_i=1, or entry bit0 (V)=0: access_error=1, mpte=entry, go to OUT.
  - V=1 and bit1 (L)=1: mpte=entry, go to OUT.
  - V=1, L=0, level>0: base = entry[53:10]<<PAGE_SHIFT, level--, go to REQ.
  - V=1, L=0, level==0: access_error=1, go to OUT.
- OUT: stage_master_valid=1. Data is held stable until stage_master_ready, then go to IDLE. stage_slave_ready stays 0 in OUT; there is no same-cycle re-accept.
- Latency, no stalls:
  - Skip transaction: accept at cycle N, master valid at N+1.
  - Walk of k levels: accept at N; each level takes 2 cycles (REQ then WAIT with a same-cycle response); master valid at N+1+2k.
- Flush (stage_ctrl_valid with the flush command) takes priority over every other event in the same cycle:
  - From IDLE, REQ or OUT: discard the transaction and go to IDLE. mem_req_valid_o drops even if unaccepted.
  - From WAIT: go to DRAIN. Wait for the outstanding response, discard it, then go to IDLE.
  - stage_status_valid pulses 1 cycle with the flush-done code on the cycle the FSM enters IDLE.
  - A transaction offered in the flush cycle is not accepted.
- Memory responses arriving in IDLE, REQ or OUT are protocol errors and are ignored.
- At most one memory request is outstanding at any time.
- Reset asserted mid-walk returns to IDLE immediately; the outstanding response is not tracked.

Test Plan:
- Skip pass-through: walking=SKIP, spa=0x1234 -> master valid 1 cycle later, mpte=0, transaction bit-identical, no mem_req_valid_o.
- SMMPT43 three-level walk: PPN=0x100, spa bits give idx 5/6/7, entries non-leaf PPN 0x200, non-leaf PPN 0x300, leaf 0x...403 -> addrs 0x100028, 0x200030, 0x300038; master data mpte=leaf, access_error=0, master valid at N+7.
- Invalid entry: level-2 response 0x0 -> one request only, access_error=1, mpte=0.
- Non-leaf at level 0 and mem_rsp_error_i=1 cases -> access_error=1 in both.
- Backpressure: mem_req_ready_i low 3 cycles and master_ready low 4 cycles -> address and data stable throughout, slave_ready=0 until the handshake completes.
- Flush in WAIT: response arrives 2 cycles after the flush -> no master valid, status pulse after the response, next transaction accepted cleanly.
